// File: rtl/mult_rr_scheduler.sv
// Round-robin front end that shares one sequential WxW multiplier among NREQ requesters.
// Runs one operation at a time and guards the wait on mul_done with a saturating timeout.
module mult_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     resp_valid,
    output logic [2*W-1:0]      resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic                mul_st,
    output logic [W-1:0]        mul_multiplicand,
    output logic [W-1:0]        mul_multiplier,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_result
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, START, ARM, RUN, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt_idx;
    logic [CW-1:0]  tcnt;

    logic [IW-1:0]  sel_idx;
    logic           sel_found;
    logic [IW:0]    cand;
    logic [CW-1:0]  tcnt_next;
    logic           tmo_hit;

    // Search upward from rr_ptr+1 so the last winner is visited last.
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a path
        // that skips the assignment infers a latch.
        sel_idx   = rr_ptr;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            if (!sel_found && req_valid[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    assign tcnt_next = (tcnt == CW'(TIMEOUT)) ? tcnt : tcnt + 1'b1;
    assign tmo_hit   = (tcnt_next == CW'(TIMEOUT));

    // NOTE: state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state            <= IDLE;
            rr_ptr           <= IW'(NREQ-1);
            gnt_idx          <= '0;
            tcnt             <= '0;
            req_ready        <= '0;
            resp_valid       <= '0;
            resp_data        <= '0;
            resp_err         <= 1'b0;
            busy             <= 1'b0;
            mul_st           <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            mul_st     <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        req_ready        <= NREQ'(1) << sel_idx;
                        mul_multiplicand <= req_a[sel_idx*W +: W];
                        mul_multiplier   <= req_b[sel_idx*W +: W];
                        gnt_idx          <= sel_idx;
                        rr_ptr           <= sel_idx;
                        mul_st           <= 1'b1;
                        busy             <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= ARM;
                end
                // A Done still high from the previous operation must fall first.
                ARM: begin
                    tcnt <= tcnt_next;
                    if (!mul_done) begin
                        state <= RUN;
                    end else if (tmo_hit) begin
                        resp_valid <= NREQ'(1) << gnt_idx;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RUN: begin
                    tcnt <= tcnt_next;
                    if (mul_done) begin
                        resp_valid <= NREQ'(1) << gnt_idx;
                        resp_data  <= mul_result;
                        state      <= RESP;
                    end else if (tmo_hit) begin
                        resp_valid <= NREQ'(1) << gnt_idx;
                        resp_err   <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
